// File: rtl/spi_txn_scheduler_if.sv
// Request/response bundle between the requesters and spi_txn_scheduler.
// Field slice i of each vector belongs to requester i.
interface spi_txn_scheduler_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [2*N_REQ-1:0] req_op;
  logic [3*N_REQ-1:0] req_a;
  logic [3*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]   rsp_valid;
  logic [4*N_REQ-1:0] rsp_data;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/spi_txn_scheduler.sv
// Round-robin scheduler sharing one SPI link to the arithmetic slave.
// Sends an 8-bit {op,a,b} frame and returns the 4-bit result.
module spi_txn_scheduler #(
  parameter int N_REQ   = 4,
  parameter int CLK_DIV = 2,
  parameter int GUARD   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_txn_scheduler_if.slave bus,
  output logic              busy,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  input  logic              miso
);
  localparam int HW = $clog2(CLK_DIV) + 1;
  localparam int GW = $clog2(GUARD) + 1;
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_DONE, S_GUARD
  } state_t;

  state_t        state, state_d;
  logic [HW-1:0] hcnt;
  logic [4:0]    ecnt;
  logic [GW-1:0] gcnt;
  logic [7:0]    frame;
  logic [3:0]    result;
  logic [PW-1:0] gnt, rr_ptr, pick, idx;
  logic          found, accept, tick;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    // Scan downwards so the first valid at/after rr_ptr wins.
    for (int j = N_REQ - 1; j >= 0; j--) begin
      idx = PW'((int'(rr_ptr) + j) % N_REQ);
      if (bus.req_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == S_IDLE && found)
      bus.req_ready[pick] = 1'b1;
  end

  assign tick = (hcnt == HW'(CLK_DIV - 1));
  assign busy = (state != S_IDLE);

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (found) begin
          state_d = S_SETUP;
          accept  = 1'b1;
        end
      end
      S_SETUP: state_d = S_SHIFT;
      S_SHIFT: begin
        if (tick && ecnt == 5'd23)
          state_d = S_DONE;
      end
      S_DONE:
        state_d = (GUARD > 1) ? S_GUARD : S_IDLE;
      S_GUARD: begin
        if (gcnt == GW'(GUARD - 2))
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs            <= 1'b1;
      sclk          <= 1'b0;
      mosi          <= 1'b0;
      hcnt          <= '0;
      ecnt          <= '0;
      gcnt          <= '0;
      frame         <= '0;
      result        <= '0;
      gnt           <= '0;
      rr_ptr        <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
    end else begin
      bus.rsp_valid <= '0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            frame  <= {bus.req_op[2*pick +: 2],
                       bus.req_a[3*pick +: 3],
                       bus.req_b[3*pick +: 3]};
            gnt    <= pick;
            rr_ptr <= (pick == PW'(N_REQ - 1)) ?
                      '0 : pick + 1'b1;
          end
        end
        S_SETUP: begin
          cs   <= 1'b0;
          hcnt <= '0;
          ecnt <= '0;
        end
        S_SHIFT: begin
          if (tick) begin
            hcnt <= '0;
            ecnt <= ecnt + 5'd1;
            // Even edge count = rising edge of period ecnt/2.
            sclk <= ~ecnt[0];
            if (!ecnt[0] && !ecnt[4])
              mosi <= frame[ecnt[3:1]];
            if (ecnt[0] && ecnt[4])
              result[ecnt[2:1]] <= miso;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        S_DONE: begin
          cs                     <= 1'b1;
          sclk                   <= 1'b0;
          mosi                   <= 1'b0;
          gcnt                   <= '0;
          bus.rsp_valid[gnt]     <= 1'b1;
          bus.rsp_data[4*gnt +: 4] <= result;
        end
        S_GUARD: gcnt <= gcnt + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Self-checking bench: table vectors, scoreboard, slave model.
// Corner sequences for round-robin, wrap, reset abort, CLK_DIV=1.
module tb_spi_txn_scheduler;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_txn_scheduler_if #(.N_REQ(N)) b0 ();
  spi_txn_scheduler_if #(.N_REQ(N)) b1 ();

  logic busy0, sclk0, cs0, mosi0;
  logic busy1, sclk1, cs1, mosi1;
  logic miso0 = 1'b0;
  logic miso1 = 1'b0;

  spi_txn_scheduler #(.N_REQ(N), .CLK_DIV(2), .GUARD(2)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .busy(busy0),
    .sclk(sclk0), .cs(cs0), .mosi(mosi0), .miso(miso0)
  );

  spi_txn_scheduler #(.N_REQ(N), .CLK_DIV(1), .GUARD(2)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .busy(busy1),
    .sclk(sclk1), .cs(cs1), .mosi(mosi1), .miso(miso1)
  );

  int vec = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    vec++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] alu(input logic [7:0] f);
    logic [3:0] a, b;
    a = {1'b0, f[5:3]};
    b = {1'b0, f[2:0]};
    case (f[7:6])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Slave models: capture mosi on falls 0..7, drive result before falls 8..11.
  logic [7:0] rx0, rx1;
  logic [3:0] res0, res1;
  int nf0 = 0;
  int nf1 = 0;
  int k0, k1;

  always @(negedge sclk0 or posedge cs0) begin
    if (cs0) nf0 = 0;
    else begin
      if (nf0 < 8) begin
        k0 = nf0;
        rx0[k0[2:0]] = mosi0;
      end
      if (nf0 == 7) res0 = alu(rx0);
      if (nf0 >= 7 && nf0 < 11) begin
        k0 = nf0 - 7;
        miso0 = res0[k0[1:0]];
      end
      nf0++;
    end
  end

  always @(negedge sclk1 or posedge cs1) begin
    if (cs1) nf1 = 0;
    else begin
      if (nf1 < 8) begin
        k1 = nf1;
        rx1[k1[2:0]] = mosi1;
      end
      if (nf1 == 7) res1 = alu(rx1);
      if (nf1 >= 7 && nf1 < 11) begin
        k1 = nf1 - 7;
        miso1 = res1[k1[1:0]];
      end
      nf1++;
    end
  end

  typedef struct {
    int         rq;
    logic [1:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic [3:0] exp;
  } vec_t;

  typedef struct {
    int         rq;
    logic [3:0] d;
    int         t0;
  } sb_t;

  vec_t       tbl [6];
  sb_t        sbq [$];
  logic [3:0] exp_for [N];

  always @(negedge clk) begin
    if (!rst_n) sbq.delete();
    else begin
      for (int i = 0; i < N; i++) begin
        if (b0.rsp_valid[i]) begin
          sb_t e;
          if (sbq.size() == 0) chk("rsp_unexpected", i, -1);
          else begin
            e = sbq.pop_front();
            chk("rsp_id", i, e.rq);
            chk("rsp_data", int'(b0.rsp_data[4*i +: 4]), int'(e.d));
            chk("rsp_latency", cyc - e.t0, 50);
          end
        end
        if (b0.req_valid[i] && b0.req_ready[i])
          sbq.push_back('{i, exp_for[i], cyc + 1});
      end
    end
  end

  int   viol0 = 0;
  int   viol1 = 0;
  int   rise1 = 0;
  int   last_rise1 = 0;
  int   per1 = 0;
  logic sclk1_q = 1'b0;

  always @(negedge clk) begin
    if (cs0 === 1'b1 && sclk0 !== 1'b0) viol0++;
    if (cs1 === 1'b1 && sclk1 !== 1'b0) viol1++;
    if (sclk1 === 1'b1 && sclk1_q === 1'b0) begin
      if (rise1 > 0) per1 = cyc - last_rise1;
      last_rise1 = cyc;
      rise1++;
    end
    sclk1_q = sclk1;
  end

  task automatic set_req(input int i, input logic [1:0] op,
                         input logic [2:0] a, input logic [2:0] b,
                         input logic [3:0] e);
    b0.req_op[2*i +: 2] = op;
    b0.req_a[3*i +: 3]  = a;
    b0.req_b[3*i +: 3]  = b;
    exp_for[i]          = e;
  endtask

  task automatic wait_grant(output int id, output int t,
                            output logic [N-1:0] rv);
    id = -1;
    t  = 0;
    rv = '0;
    for (int n = 0; n < 200 && id < 0; n++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (b0.req_valid[i] && b0.req_ready[i]) begin
          id = i;
          t  = cyc + 1;
          rv = b0.req_ready;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || busy0 !== 1'b0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", int'(n >= 400), 0);
    @(posedge clk);
    #1;
  endtask

  int         id, t, prev, got, lat;
  logic [N-1:0] rv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    b0.req_valid = '0;
    b0.req_op    = '0;
    b0.req_a     = '0;
    b0.req_b     = '0;
    b1.req_valid = '0;
    b1.req_op    = '0;
    b1.req_a     = '0;
    b1.req_b     = '0;
    for (int i = 0; i < N; i++) exp_for[i] = '0;

    tbl[0] = '{0, 2'd0, 3'd3, 3'd2, 4'd5};
    tbl[1] = '{1, 2'd1, 3'd5, 3'd7, 4'hE};
    tbl[2] = '{2, 2'd2, 3'd6, 3'd3, 4'd2};
    tbl[3] = '{3, 2'd3, 3'd5, 3'd6, 4'd3};
    tbl[4] = '{0, 2'd0, 3'd7, 3'd7, 4'hE};
    tbl[5] = '{2, 2'd1, 3'd7, 3'd0, 4'd7};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", int'(cs0), 1);
    chk("rst_sclk", int'(sclk0), 0);
    chk("rst_mosi", int'(mosi0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_rsp_valid", int'(b0.rsp_valid), 0);
    chk("rst_rsp_data", int'(b0.rsp_data), 0);
    chk("rst_cs_u1", int'(cs1), 1);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_ready", int'(b0.req_ready), 0);
    chk("idle_busy", int'(busy0), 0);

    for (int v = 0; v < 6; v++) begin
      set_req(tbl[v].rq, tbl[v].op, tbl[v].a, tbl[v].b, tbl[v].exp);
      b0.req_valid[tbl[v].rq] = 1'b1;
      wait_grant(id, t, rv);
      b0.req_valid[tbl[v].rq] = 1'b0;
      chk("tbl_grant", id, tbl[v].rq);
      drain();
      chk("tbl_frame", int'(rx0),
          int'({tbl[v].op, tbl[v].a, tbl[v].b}));
    end
    chk("hold_rsp0", int'(b0.rsp_data[3:0]), 14);
    chk("hold_rsp1", int'(b0.rsp_data[7:4]), 14);
    chk("hold_rsp2", int'(b0.rsp_data[11:8]), 7);
    chk("hold_rsp3", int'(b0.rsp_data[15:12]), 3);

    // Round-robin with every requester pending from reset.
    rst_n = 1'b0;
    for (int i = 0; i < N; i++)
      set_req(i, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);
    b0.req_valid = '1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(id, t, rv);
      chk("rr_grant", id, g % N);
      chk("rr_onehot", $countones(rv), 1);
      if (g > 0) chk("rr_spacing", t - prev, 52);
      prev = t;
    end
    b0.req_valid = '0;
    drain();

    // Pointer wrap: pointer now at 1.
    b0.req_valid[2] = 1'b1;
    wait_grant(id, t, rv);
    b0.req_valid[2] = 1'b0;
    chk("wrap_grant2", id, 2);
    b0.req_valid[1] = 1'b1;
    b0.req_valid[3] = 1'b1;
    wait_grant(id, t, rv);
    b0.req_valid[3] = 1'b0;
    chk("wrap_grant3", id, 3);
    wait_grant(id, t, rv);
    b0.req_valid[1] = 1'b0;
    chk("wrap_grant1", id, 1);
    drain();

    // Operands change after accept; frame and held data unaffected.
    set_req(1, 2'd1, 3'd5, 3'd1, 4'd4);
    b0.req_valid[1] = 1'b1;
    wait_grant(id, t, rv);
    b0.req_valid[1] = 1'b0;
    b0.req_a[5:3] = 3'd0;
    b0.req_b[5:3] = 3'd7;
    drain();
    chk("latch_frame", int'(rx0), int'(8'b01_101_001));
    repeat (20) @(posedge clk);
    #1;
    chk("latch_hold1", int'(b0.rsp_data[7:4]), 4);
    set_req(2, 2'd2, 3'd7, 3'd5, 4'd5);
    b0.req_valid[2] = 1'b1;
    wait_grant(id, t, rv);
    b0.req_valid[2] = 1'b0;
    drain();
    chk("latch_hold1b", int'(b0.rsp_data[7:4]), 4);
    chk("latch_rsp2", int'(b0.rsp_data[11:8]), 5);

    // Reset abort after rising edge k=4.
    set_req(0, 2'd0, 3'd1, 3'd6, 4'd7);
    b0.req_valid[0] = 1'b1;
    wait_grant(id, t, rv);
    chk("abort_grant", id, 0);
    repeat (19) @(posedge clk);
    #1;
    chk("abort_sclk_hi", int'(sclk0), 1);
    chk("abort_cs_lo", int'(cs0), 0);
    rst_n = 1'b0;
    #1;
    chk("abort_cs", int'(cs0), 1);
    chk("abort_sclk", int'(sclk0), 0);
    chk("abort_busy", int'(busy0), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_rsp_valid", int'(b0.rsp_valid), 0);
    rst_n = 1'b1;
    wait_grant(id, t, rv);
    b0.req_valid[0] = 1'b0;
    chk("abort_regrant", id, 0);
    drain();
    chk("abort_frame", int'(rx0), int'(8'b00_001_110));
    chk("abort_rsp0", int'(b0.rsp_data[3:0]), 7);

    // CLK_DIV=1 instance.
    b1.req_op[5:4]  = 2'd0;
    b1.req_a[8:6]   = 3'd7;
    b1.req_b[8:6]   = 3'd7;
    b1.req_valid[2] = 1'b1;
    id = -1;
    for (int n = 0; n < 50 && id < 0; n++) begin
      @(negedge clk);
      if (b1.req_ready[2]) begin
        id = 2;
        t  = cyc + 1;
      end
    end
    @(posedge clk);
    #1;
    b1.req_valid[2] = 1'b0;
    chk("cd1_grant", id, 2);
    got = 0;
    lat = 0;
    for (int n = 0; n < 100 && got == 0; n++) begin
      @(negedge clk);
      if (b1.rsp_valid[2]) begin
        got = 1;
        lat = cyc - t;
      end
    end
    chk("cd1_rsp_seen", got, 1);
    chk("cd1_latency", lat, 26);
    chk("cd1_data", int'(b1.rsp_data[11:8]), 14);
    chk("cd1_frame", int'(rx1), int'(8'h3F));
    chk("cd1_rises", rise1, 12);
    chk("cd1_period", per1, 2);
    repeat (5) @(posedge clk);
    #1;
    chk("sclk_while_cs_u0", viol0, 0);
    chk("sclk_while_cs_u1", viol1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
